serial_divisibility_detector: RTL and testbench
===============================================

// Module: serial_divisibility_detector
// PURPOSE
//  - Accepts a WIDTH-bit word serially, MSB first, over a valid/ready bit interface.
//  - Keeps a running remainder modulo DIV_A and modulo DIV_B.
//  - At end of word, flags whether the word is a nonzero multiple of each divisor.
//  - Serial, parametrised successor of the 4-bit divisible-by-3 / divisible-by-2 LED decoder; drives board LEDs from a switch/serial source.
// PARAMETERS
//  WIDTH  4  bits per word; >= 1
//  DIV_A  3  first divisor; >= 2
//  DIV_B  2  second divisor; >= 2
// PORTS
//  clk        in   1  single clock, rising edge
//  rst_n      in   1  reset, asynchronous assert, active-low
//  start      in   1  begin a new word; clears remainders and count
//  bit_valid  in   1  bit_in is valid this cycle
//  bit_in     in   1  serial data, MSB first
//  ready      out  1  block accepts bit_in this cycle
//  busy       out  1  word in progress (state SHIFT)
//  done       out  1  one-cycle pulse; flags updated this cycle
//  div_a      out  1  last word nonzero and (word % DIV_A)==0
//  div_b      out  1  last word nonzero and (word % DIV_B)==0
//  rem_a      out  RW_A  running remainder mod DIV_A; only with DIVDET_REMAINDER_OUT_EN
//  rem_b      out  RW_B  running remainder mod DIV_B; only with DIVDET_REMAINDER_OUT_EN
// BEHAVIOUR
//  - Reset: state=IDLE, done=0, busy=0, ready=0, div_a=0, div_b=0, remainders=0, count=0, nonzero=0.
//  - FSM states:
//    - IDLE: ready=0. start -> SHIFT. bits are ignored.
//    - SHIFT: ready=1, busy=1. A bit is accepted when bit_valid && ready && !start.
//    - DONE: done=1 for exactly one cycle, ready=0, then -> IDLE, or -> SHIFT if start is high.
//  - Bit acceptance updates:
//    - r' = 2r + b; if r' >= D then r' -= D. Single subtract suffices since 2r+b < 2D.
//    - Internal width is $clog2(D)+1.
//    - nonzero |= b; count increments.
//  - When the WIDTH-th bit is accepted: next cycle state=DONE, done=1.
//    - div_a = (rem_a==0) && nonzero; likewise div_b.
//  - Latency: flags valid exactly 1 cycle after the last accepted bit.
//    - Flags hold until the next done; they are not cleared by start.
//  - bit_valid gaps: no effect; count and remainders hold.
//  - start in SHIFT aborts the word: remainders, count and nonzero clear, stay in SHIFT, no done.
//  - start has priority over a simultaneous bit_valid; that bit is dropped.
//  - rst_n low mid-word: immediate return to reset values; the partial word is lost, no done.
//  - All-zero word: div_a=div_b=0 (zero is not flagged).
// CONFIGURATION
//  - DIVDET_REMAINDER_OUT_EN defined: rem_a/rem_b ports exist.
//    - They show the registered running remainders, updated the cycle after each accepted bit.
//    - They are zero after start or reset, and hold through DONE/IDLE.
//  - Undefined: ports absent; remainders remain internal only. Other behaviour identical.
// STRUCTURE
//  - Package divdet_pkg:
//    - state enum {IDLE, SHIFT, DONE};
//    - function rem_w(D) = $clog2(D)+1;
//    - count width = $clog2(WIDTH+1).
//  - Sub-module mod_step_reg (param DIV): clear, en, bit_in -> registered remainder.
//    - Instantiated twice (DIV_A, DIV_B).
//  - Top holds the FSM, bit counter, nonzero flag and output flags.
// TESTING
//  - Defaults, start then bits 0,1,1,0 back-to-back -> done at cycle 5 after first bit, div_a=1, div_b=1.
//  - Defaults, word 1001 with 2 idle cycles between each bit -> div_a=1, div_b=0, done single pulse.
//  - Defaults, all 16 words -> flags equal golden (v!=0 && v%3==0, v!=0 && v%2==0); 0000 gives 0,0.
//  - Word 1,1 then start + bit_valid=1 same cycle, then 1,1,1,1 -> first bit after abort dropped; result 1111 -> div_a=1, div_b=0.
//  - rst_n low after 2 bits -> all outputs 0 next edge, no done; a new word after reset is evaluated correctly.
//  - WIDTH=8, DIV_A=7, DIV_B=5, word 0x23 (35) -> div_a=1, div_b=1; with macro, rem_a=0, rem_b=0; word 0x24 -> 0,0, rem_a=1, rem_b=1.

Source files
------------

// File: rtl/divdet_pkg.sv
// Shared types and width helpers for the serial divisibility detector.
// rem_step is the single modular-accumulate step used by both the register and the flag logic.
package divdet_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int rem_w(input int d);
        return $clog2(d) + 1;
    endfunction

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    // 2r+b < 2d whenever r < d, so one conditional subtract keeps the result in [0, d).
    function automatic int rem_step(input int r, input logic b, input int d);
        int t;
        t = 2 * r + int'(b);
        return (t >= d) ? (t - d) : t;
    endfunction

endpackage

// File: rtl/divdet_mod_step_reg.sv
// Registered running remainder modulo DIV of an MSB-first bit stream.
// Updates one cycle after en_i; clear_i wins over en_i and zeroes the remainder.
module mod_step_reg
    import divdet_pkg::*;
#(
    parameter int DIV = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear_i,
    input  logic                    en_i,
    input  logic                    bit_i,
    output logic [rem_w(DIV)-1:0]   rem_o
);

    localparam int RW = rem_w(DIV);

    logic [RW-1:0] rem_q;
    logic [RW-1:0] rem_d;

    always_comb begin
        rem_d = rem_q;
        if (clear_i) begin
            rem_d = '0;
        end else if (en_i) begin
            rem_d = RW'(rem_step(int'(rem_q), bit_i, DIV));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
        end else begin
            rem_q <= rem_d;
        end
    end

    assign rem_o = rem_q;

endmodule

// File: rtl/serial_divisibility_detector.sv
// Serial MSB-first word divisibility check against DIV_A and DIV_B; flags land with done, 1 cycle after the last bit.
// ready only in SHIFT, start always wins over a bit; DIVDET_REMAINDER_OUT_EN exposes the running remainders.
module serial_divisibility_detector
    import divdet_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV_A = 3,
    parameter int DIV_B = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        bit_valid,
    input  logic                        bit_in,
    output logic                        ready,
    output logic                        busy,
    output logic                        done,
    output logic                        div_a,
    output logic                        div_b
`ifdef DIVDET_REMAINDER_OUT_EN
    ,
    output logic [rem_w(DIV_A)-1:0]     rem_a,
    output logic [rem_w(DIV_B)-1:0]     rem_b
`endif
);

    localparam int CW   = cnt_w(WIDTH);
    localparam int RW_A = rem_w(DIV_A);
    localparam int RW_B = rem_w(DIV_B);

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            nonzero_q, nonzero_d;
    logic            div_a_q, div_a_d;
    logic            div_b_q, div_b_d;
    logic [RW_A-1:0] rem_a_q;
    logic [RW_B-1:0] rem_b_q;
    logic            accept;
    logic            last_bit;
    logic            nonzero_nxt;
    int              rem_a_fin;
    int              rem_b_fin;

    assign accept      = bit_valid && (state_q == SHIFT) && !start;
    assign last_bit    = accept && (count_q == CW'(WIDTH - 1));
    assign nonzero_nxt = nonzero_q | bit_in;

    // Remainder after the bit being accepted now, so flags are ready together with done.
    assign rem_a_fin = rem_step(int'(rem_a_q), bit_in, DIV_A);
    assign rem_b_fin = rem_step(int'(rem_b_q), bit_in, DIV_B);

    mod_step_reg #(
        .DIV (DIV_A)
    ) u_mod_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (start),
        .en_i    (accept),
        .bit_i   (bit_in),
        .rem_o   (rem_a_q)
    );

    mod_step_reg #(
        .DIV (DIV_B)
    ) u_mod_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (start),
        .en_i    (accept),
        .bit_i   (bit_in),
        .rem_o   (rem_b_q)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        nonzero_d = nonzero_q;
        div_a_d   = div_a_q;
        div_b_d   = div_b_q;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SHIFT;
                    count_d   = '0;
                    nonzero_d = 1'b0;
                end
            end
            SHIFT: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (start) begin
                    count_d   = '0;
                    nonzero_d = 1'b0;
                end else if (accept) begin
                    count_d   = count_q + 1'b1;
                    nonzero_d = nonzero_nxt;
                    if (last_bit) begin
                        state_d = DONE;
                        div_a_d = (rem_a_fin == 0) && nonzero_nxt;
                        div_b_d = (rem_b_fin == 0) && nonzero_nxt;
                    end
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_d   = SHIFT;
                    count_d   = '0;
                    nonzero_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            nonzero_q <= 1'b0;
            div_a_q   <= 1'b0;
            div_b_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            nonzero_q <= nonzero_d;
            div_a_q   <= div_a_d;
            div_b_q   <= div_b_d;
        end
    end

    assign div_a = div_a_q;
    assign div_b = div_b_q;

`ifdef DIVDET_REMAINDER_OUT_EN
    assign rem_a = rem_a_q;
    assign rem_b = rem_b_q;
`endif

endmodule

// File: tb/tb_serial_divisibility_detector.sv
// Directed and random words on a default instance and a WIDTH=8/7/5 instance, checked against integer arithmetic.
module tb_serial_divisibility_detector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic a_start, a_valid, a_bit, a_ready, a_busy, a_done, a_da, a_db;
    logic b_start, b_valid, b_bit, b_ready, b_busy, b_done, b_da, b_db;
`ifdef DIVDET_REMAINDER_OUT_EN
    logic [2:0] a_rem_a;
    logic [1:0] a_rem_b;
    logic [3:0] b_rem_a;
    logic [3:0] b_rem_b;
`endif

    serial_divisibility_detector u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (a_start),
        .bit_valid (a_valid),
        .bit_in    (a_bit),
        .ready     (a_ready),
        .busy      (a_busy),
        .done      (a_done),
        .div_a     (a_da),
        .div_b     (a_db)
`ifdef DIVDET_REMAINDER_OUT_EN
        ,
        .rem_a     (a_rem_a),
        .rem_b     (a_rem_b)
`endif
    );

    serial_divisibility_detector #(
        .WIDTH (8),
        .DIV_A (7),
        .DIV_B (5)
    ) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (b_start),
        .bit_valid (b_valid),
        .bit_in    (b_bit),
        .ready     (b_ready),
        .busy      (b_busy),
        .done      (b_done),
        .div_a     (b_da),
        .div_b     (b_db)
`ifdef DIVDET_REMAINDER_OUT_EN
        ,
        .rem_a     (b_rem_a),
        .rem_b     (b_rem_b)
`endif
    );

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    int W  [2] = '{4, 8};
    int DA [2] = '{3, 7};
    int DB [2] = '{2, 5};
    int exp_da [2] = '{0, 0};
    int exp_db [2] = '{0, 0};

    logic [31:0] o_ready, o_busy, o_done, o_da, o_db, o_ra, o_rb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic snap(input int sel);
        if (sel == 0) begin
            o_ready = {31'b0, a_ready};
            o_busy  = {31'b0, a_busy};
            o_done  = {31'b0, a_done};
            o_da    = {31'b0, a_da};
            o_db    = {31'b0, a_db};
`ifdef DIVDET_REMAINDER_OUT_EN
            o_ra    = {29'b0, a_rem_a};
            o_rb    = {30'b0, a_rem_b};
`endif
        end else begin
            o_ready = {31'b0, b_ready};
            o_busy  = {31'b0, b_busy};
            o_done  = {31'b0, b_done};
            o_da    = {31'b0, b_da};
            o_db    = {31'b0, b_db};
`ifdef DIVDET_REMAINDER_OUT_EN
            o_ra    = {28'b0, b_rem_a};
            o_rb    = {28'b0, b_rem_b};
`endif
        end
    endtask

    task automatic drv(input int sel, input logic st, input logic v, input logic b);
        if (sel == 0) begin
            a_start = st; a_valid = v; a_bit = b;
        end else begin
            b_start = st; b_valid = v; b_bit = b;
        end
    endtask

    // Shift in the W LSBs of v MSB first with gap idle cycles between bits; ends on the cycle after done.
    task automatic shift_bits(input int sel, input int v, input int gap, input string tag);
        int   pref;
        logic b;
        pref = 0;
        for (int i = W[sel] - 1; i >= 0; i--) begin
            b = ((v >> i) & 1) != 0;
            drv(sel, 1'b0, 1'b1, b);
            @(negedge clk);
            drv(sel, 1'b0, 1'b0, 1'b0);
            pref = pref * 2 + (b ? 1 : 0);
            snap(sel);
`ifdef DIVDET_REMAINDER_OUT_EN
            check({tag, " rem_a"}, o_ra, pref % DA[sel]);
            check({tag, " rem_b"}, o_rb, pref % DB[sel]);
`endif
            if (i > 0) begin
                check({tag, " early done"}, o_done, 0);
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    snap(sel);
                    check({tag, " gap done"}, o_done, 0);
                    check({tag, " gap busy"}, o_busy, 1);
                end
            end
        end
        exp_da[sel] = (v != 0 && v % DA[sel] == 0) ? 1 : 0;
        exp_db[sel] = (v != 0 && v % DB[sel] == 0) ? 1 : 0;
        check({tag, " done"}, o_done, 1);
        check({tag, " busy in done"}, o_busy, 0);
        check({tag, " ready in done"}, o_ready, 0);
        check({tag, " div_a"}, o_da, exp_da[sel]);
        check({tag, " div_b"}, o_db, exp_db[sel]);
        @(negedge clk);
        snap(sel);
        check({tag, " done pulse"}, o_done, 0);
        check({tag, " div_a hold"}, o_da, exp_da[sel]);
        check({tag, " div_b hold"}, o_db, exp_db[sel]);
`ifdef DIVDET_REMAINDER_OUT_EN
        check({tag, " rem_a hold"}, o_ra, v % DA[sel]);
        check({tag, " rem_b hold"}, o_rb, v % DB[sel]);
`endif
    endtask

    task automatic send_word(input int sel, input int v, input int gap, input string tag);
        drv(sel, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drv(sel, 1'b0, 1'b0, 1'b0);
        snap(sel);
        check({tag, " busy after start"}, o_busy, 1);
        check({tag, " ready after start"}, o_ready, 1);
        check({tag, " div_a kept by start"}, o_da, exp_da[sel]);
        check({tag, " div_b kept by start"}, o_db, exp_db[sel]);
`ifdef DIVDET_REMAINDER_OUT_EN
        check({tag, " rem_a cleared"}, o_ra, 0);
`endif
        shift_bits(sel, v, gap, tag);
    endtask

    initial begin
        int v;
        int g;
        drv(0, 1'b0, 1'b0, 1'b0);
        drv(1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            snap(s);
            check("reset ready", o_ready, 0);
            check("reset busy", o_busy, 0);
            check("reset done", o_done, 0);
            check("reset div_a", o_da, 0);
            check("reset div_b", o_db, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // IDLE ignores bits
        drv(0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        drv(0, 1'b0, 1'b0, 1'b0);
        snap(0);
        check("idle ready", o_ready, 0);
        check("idle busy", o_busy, 0);

        send_word(0, 4'b0110, 0, "w0110");

        // Abort after two bits; the bit presented with start is dropped.
        drv(0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            drv(0, 1'b0, 1'b1, 1'b1);
            @(negedge clk);
        end
        drv(0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        drv(0, 1'b0, 1'b0, 1'b0);
        snap(0);
        check("abort busy", o_busy, 1);
        check("abort no done", o_done, 0);
`ifdef DIVDET_REMAINDER_OUT_EN
        check("abort rem_a", o_ra, 0);
        check("abort rem_b", o_rb, 0);
`endif
        shift_bits(0, 4'b1111, 0, "abort w1111");

        // Reset mid-word after two bits
        drv(0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drv(0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        drv(0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drv(0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        snap(0);
        check("midreset busy", o_busy, 0);
        check("midreset ready", o_ready, 0);
        check("midreset div_a", o_da, 0);
        @(negedge clk);
        snap(0);
        check("midreset done", o_done, 0);
        check("midreset div_b", o_db, 0);
        rst_n = 1'b1;
        exp_da = '{0, 0};
        exp_db = '{0, 0};
        @(negedge clk);

        send_word(0, 4'b1001, 2, "w1001 gap2");

        for (int w = 0; w < 16; w++) begin
            send_word(0, w, 0, $sformatf("all16 %0d", w));
        end

        send_word(1, 8'h23, 0, "w8 0x23");
        send_word(1, 8'h24, 1, "w8 0x24");

        for (int r = 0; r < 24; r++) begin
            v = int'($urandom_range(0, 15));
            g = int'($urandom_range(0, 2));
            send_word(0, v, g, $sformatf("rand4 %0d", v));
            v = int'($urandom_range(0, 255));
            g = int'($urandom_range(0, 2));
            send_word(1, v, g, $sformatf("rand8 %0d", v));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
